music_scheduler: RTL and testbench

- Sequences the shared tone/note datapath between background music (BGM) and short sound effects (SFX).
- Generates the beat tick and selects the BGM track from scene/boss. Inserts a silent gap on every track change.
- Preempts BGM for SFX, then resumes BGM at the saved beat.
- Sits between the game FSM and the note-lookup/tone-generator; its track/ibeat outputs address the note ROMs.

---
 rtl/music_pkg.sv | 33 +++
 rtl/music_scheduler_if.sv | 37 +++
 rtl/beat_divider.sv | 31 +++
 rtl/music_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_music_scheduler.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared definitions for music_scheduler: track IDs, FSM state encoding,
// default track lengths and the scene/boss to BGM track mapping.
package music_pkg;

   localparam logic [2:0] TRK_START = 3'd0;
   localparam logic [2:0] TRK_GAME  = 3'd1;
   localparam logic [2:0] TRK_BOSS  = 3'd2;
   localparam logic [2:0] TRK_WIN   = 3'd3;
   localparam logic [2:0] TRK_LOSE  = 3'd4;
   localparam logic [2:0] TRK_SFX   = 3'd5;

   typedef enum logic [1:0] {
      ST_PLAY = 2'd0,
      ST_GAP  = 2'd1,
      ST_SFX  = 2'd2
   } state_e;

   localparam int DEF_LEN_START = 133;
   localparam int DEF_LEN_GAME  = 768;
   localparam int DEF_LEN_BOSS  = 352;
   localparam int DEF_LEN_WIN   = 297;
   localparam int DEF_LEN_LOSE  = 136;

   function automatic logic [2:0] target_track(input logic [1:0] scene, input logic boss);
      case (scene)
         2'b00:   target_track = TRK_START;
         2'b01:   target_track = boss ? TRK_BOSS : TRK_GAME;
         2'b10:   target_track = TRK_WIN;
         default: target_track = TRK_LOSE;
      endcase
   endfunction

endpackage

// File: rtl/music_scheduler_if.sv
// Game-FSM side bundle of music_scheduler: scene/SFX requests in, note-ROM addressing out.
// With MUSIC_SCHED_PAUSE_EN defined the bundle also carries the pause input.
interface music_scheduler_if;
   import music_pkg::*;

   logic [1:0] scene;
   logic       boss;
   logic       sfx_req;
   logic [1:0] sfx_id;
`ifdef MUSIC_SCHED_PAUSE_EN
   logic       pause;
`endif
   logic [2:0] track;
   logic [9:0] ibeat;
   logic [1:0] sfx_sel;
   logic       sfx_active;
   logic       mute;
   logic       beat_tick;
   logic       track_done;

   modport master (
`ifdef MUSIC_SCHED_PAUSE_EN
      output pause,
`endif
      output scene, boss, sfx_req, sfx_id,
      input  track, ibeat, sfx_sel, sfx_active, mute, beat_tick, track_done
   );

   modport slave (
`ifdef MUSIC_SCHED_PAUSE_EN
      input  pause,
`endif
      input  scene, boss, sfx_req, sfx_id,
      output track, ibeat, sfx_sel, sfx_active, mute, beat_tick, track_done
   );

endinterface

// File: rtl/beat_divider.sv
// Free-running beat divider: counts 0..CLK_DIV-1 and flags the last count as the beat tick.
// freeze holds the count and suppresses the tick so timing resumes exactly where it stopped.
module beat_divider #(
   parameter int CLK_DIV = 3125000
) (
   input  logic clk,
   input  logic reset,
   input  logic freeze,
   output logic beat_tick
);

   localparam int            CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!freeze) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign beat_tick = (cnt_q == LAST) && !freeze;

endmodule

// File: rtl/music_scheduler.sv
// music_scheduler: shares the tone/note datapath between BGM tracks (with a silent gap on
// track change) and preempting SFX. Optional MUSIC_SCHED_PAUSE_EN adds a pause input.
//
// state   | meaning
// ST_PLAY | BGM owns the datapath; muted only once a one-shot track has finished
// ST_GAP  | silent gap after a BGM track change, counts GAP_BEATS beat ticks
// ST_SFX  | SFX owns the datapath (track 5); BGM beat parked in saved_q
module music_scheduler
   import music_pkg::*;
#(
   parameter int CLK_DIV   = 3125000,
   parameter int GAP_BEATS = 4,
   parameter int SFX_LEN   = 8,
   parameter int LEN_START = DEF_LEN_START,
   parameter int LEN_GAME  = DEF_LEN_GAME,
   parameter int LEN_BOSS  = DEF_LEN_BOSS,
   parameter int LEN_WIN   = DEF_LEN_WIN,
   parameter int LEN_LOSE  = DEF_LEN_LOSE
) (
   input logic              clk,
   input logic              reset,
   music_scheduler_if.slave bus
);

   localparam int            GW       = $clog2(GAP_BEATS + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BEATS - 1);
   localparam logic [9:0]    SFX_LAST = 10'(SFX_LEN - 1);

   function automatic logic [9:0] last_beat(input logic [2:0] trk);
      case (trk)
         TRK_START: last_beat = 10'(LEN_START - 1);
         TRK_GAME:  last_beat = 10'(LEN_GAME - 1);
         TRK_BOSS:  last_beat = 10'(LEN_BOSS - 1);
         TRK_WIN:   last_beat = 10'(LEN_WIN - 1);
         default:   last_beat = 10'(LEN_LOSE - 1);
      endcase
   endfunction

   logic       freeze;
   logic       tick;
   logic [2:0] target;
   logic       one_shot;

`ifdef MUSIC_SCHED_PAUSE_EN
   assign freeze = bus.pause;
`else
   assign freeze = 1'b0;
`endif

   beat_divider #(.CLK_DIV(CLK_DIV)) u_beat_divider (
      .clk       (clk),
      .reset     (reset),
      .freeze    (freeze),
      .beat_tick (tick)
   );

   state_e        state_q, state_d;
   logic [2:0]    bgm_q, bgm_d;
   logic [2:0]    track_q, track_d;
   logic [9:0]    ibeat_q, ibeat_d;
   logic [9:0]    saved_q, saved_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [1:0]    sel_q, sel_d;
   logic          fin_q, fin_d;
   logic          active_q, active_d;
   logic          mute_q, mute_d;
   logic          done_q, done_d;

   assign target   = target_track(bus.scene, bus.boss);
   assign one_shot = (bgm_q == TRK_WIN) || (bgm_q == TRK_LOSE);

   always_comb begin
      state_d  = state_q;
      bgm_d    = bgm_q;
      track_d  = track_q;
      ibeat_d  = ibeat_q;
      saved_d  = saved_q;
      gap_d    = gap_q;
      sel_d    = sel_q;
      fin_d    = fin_q;
      active_d = active_q;
      mute_d   = mute_q;
      done_d   = 1'b0;

      // While frozen everything holds; a pending target change is picked up on release.
      if (!freeze) begin
         case (state_q)
            ST_GAP: begin
               if (target != bgm_q) begin
                  bgm_d   = target;
                  track_d = target;
                  gap_d   = '0;
               end else if (tick) begin
                  if (gap_q == GAP_LAST) begin
                     state_d = ST_PLAY;
                     ibeat_d = '0;
                     mute_d  = 1'b0;
                     fin_d   = 1'b0;
                  end else begin
                     gap_d = gap_q + 1'b1;
                  end
               end
            end
            default: begin
               if (target != bgm_q) begin
                  state_d  = ST_GAP;
                  bgm_d    = target;
                  track_d  = target;
                  gap_d    = '0;
                  ibeat_d  = '0;
                  fin_d    = 1'b0;
                  mute_d   = 1'b1;
                  active_d = 1'b0;
               end else if (bus.sfx_req) begin
                  // A retrigger inside SFX must not overwrite the parked BGM beat.
                  if (state_q == ST_PLAY) saved_d = ibeat_q;
                  state_d  = ST_SFX;
                  sel_d    = bus.sfx_id;
                  ibeat_d  = '0;
                  track_d  = TRK_SFX;
                  active_d = 1'b1;
                  mute_d   = 1'b0;
               end else if (tick) begin
                  if (state_q == ST_SFX) begin
                     if (ibeat_q == SFX_LAST) begin
                        state_d  = ST_PLAY;
                        ibeat_d  = saved_q;
                        track_d  = bgm_q;
                        active_d = 1'b0;
                        mute_d   = fin_q;
                     end else begin
                        ibeat_d = ibeat_q + 1'b1;
                     end
                  end else if (!fin_q) begin
                     if (ibeat_q == last_beat(bgm_q)) begin
                        if (one_shot) begin
                           fin_d  = 1'b1;
                           mute_d = 1'b1;
                           done_d = 1'b1;
                        end else begin
                           ibeat_d = '0;
                        end
                     end else begin
                        ibeat_d = ibeat_q + 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_PLAY;
         bgm_q    <= TRK_START;
         track_q  <= TRK_START;
         ibeat_q  <= '0;
         saved_q  <= '0;
         gap_q    <= '0;
         sel_q    <= '0;
         fin_q    <= 1'b0;
         active_q <= 1'b0;
         mute_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bgm_q    <= bgm_d;
         track_q  <= track_d;
         ibeat_q  <= ibeat_d;
         saved_q  <= saved_d;
         gap_q    <= gap_d;
         sel_q    <= sel_d;
         fin_q    <= fin_d;
         active_q <= active_d;
         mute_q   <= mute_d;
         done_q   <= done_d;
      end
   end

   assign bus.track      = track_q;
   assign bus.ibeat      = ibeat_q;
   assign bus.sfx_sel    = sel_q;
   assign bus.sfx_active = active_q;
   assign bus.mute       = mute_q | freeze;
   assign bus.beat_tick  = tick;
   assign bus.track_done = done_q;

endmodule

// File: tb/tb_music_scheduler.sv
// Directed plus randomized bench for music_scheduler against a beat-level reference model.
// Pause steps are exercised only when MUSIC_SCHED_PAUSE_EN is defined.
module tb_music_scheduler;

   localparam int CLK_DIV   = 4;
   localparam int GAP_BEATS = 2;
   localparam int SFX_LEN   = 3;
   localparam int LEN_T [5] = '{5, 10, 6, 3, 4};

   logic clk = 1'b0;
   logic reset;
   logic pause_v;

   music_scheduler_if bus();

`ifdef MUSIC_SCHED_PAUSE_EN
   assign bus.pause = pause_v;
`endif

   music_scheduler #(
      .CLK_DIV   (CLK_DIV),
      .GAP_BEATS (GAP_BEATS),
      .SFX_LEN   (SFX_LEN),
      .LEN_START (LEN_T[0]),
      .LEN_GAME  (LEN_T[1]),
      .LEN_BOSS  (LEN_T[2]),
      .LEN_WIN   (LEN_T[3]),
      .LEN_LOSE  (LEN_T[4])
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n;
   int seq_a [5] = '{2, 3, 4, 0, 1};

   // Reference model: mode 0 = music, 1 = silent gap, 2 = effect.
   int m_mode, m_bgm, m_beat, m_sfx_pos, m_gap_left, m_sel, m_phase;
   bit m_fin, m_done;

   function automatic int tgt_of(input logic [1:0] s, input logic b);
      if (s == 2'd0) return 0;
      if (s == 2'd1) return b ? 2 : 1;
      if (s == 2'd2) return 3;
      return 4;
   endfunction

   function automatic bit m_tick();
      return (m_phase == CLK_DIV - 1) && !pause_v;
   endfunction

   function automatic int e_track();
      return (m_mode == 2) ? 5 : m_bgm;
   endfunction

   function automatic int e_ibeat();
      if (m_mode == 1) return 0;
      if (m_mode == 2) return m_sfx_pos;
      return m_beat;
   endfunction

   function automatic bit e_mute();
      if (pause_v) return 1'b1;
      if (m_mode == 1) return 1'b1;
      if (m_mode == 2) return 1'b0;
      return m_fin;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_bgm = 0; m_beat = 0; m_sfx_pos = 0;
      m_gap_left = 0; m_sel = 0; m_phase = 0; m_fin = 0; m_done = 0;
   endtask

   task automatic model_adv();
      bit tk;
      int tgt;
      tk = m_tick();
      m_done = 0;
      if (pause_v) return;
      m_phase = (m_phase + 1) % CLK_DIV;
      tgt = tgt_of(bus.scene, bus.boss);
      if (m_mode == 1) begin
         if (tgt != m_bgm) begin
            m_bgm = tgt; m_gap_left = GAP_BEATS;
         end else if (tk) begin
            m_gap_left--;
            if (m_gap_left == 0) begin m_mode = 0; m_beat = 0; m_fin = 0; end
         end
      end else if (tgt != m_bgm) begin
         m_mode = 1; m_bgm = tgt; m_gap_left = GAP_BEATS; m_fin = 0;
      end else if (bus.sfx_req) begin
         m_mode = 2; m_sfx_pos = 0; m_sel = bus.sfx_id;
      end else if (tk) begin
         if (m_mode == 2) begin
            if (m_sfx_pos == SFX_LEN - 1) m_mode = 0;
            else m_sfx_pos++;
         end else if (!m_fin) begin
            if (m_beat < LEN_T[m_bgm] - 1) m_beat++;
            else if (m_bgm >= 3) begin m_fin = 1; m_done = 1; end
            else m_beat = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("track",      bus.track,      e_track());
      chk("ibeat",      bus.ibeat,      e_ibeat());
      chk("sfx_active", bus.sfx_active, (m_mode == 2));
      chk("sfx_sel",    bus.sfx_sel,    m_sel);
      chk("mute",       bus.mute,       e_mute());
      chk("beat_tick",  bus.beat_tick,  m_tick());
      chk("track_done", bus.track_done, m_done);
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      model_adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; pause_v = 1'b0;
      bus.scene = 2'd0; bus.boss = 1'b0; bus.sfx_req = 1'b0; bus.sfx_id = 2'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Get into an SFX so the mid-run reset has non-zero outputs to clear.
      step();
      bus.sfx_req = 1'b1; bus.sfx_id = 2'd3;
      step();
      bus.sfx_req = 1'b0;
      repeat (3) step();
      chk("pre_reset_active", bus.sfx_active, 1);

      #2 reset = 1'b0;
      #1;
      chk("rst_track",  bus.track, 0);
      chk("rst_ibeat",  bus.ibeat, 0);
      chk("rst_sel",    bus.sfx_sel, 0);
      chk("rst_active", bus.sfx_active, 0);
      chk("rst_mute",   bus.mute, 0);
      chk("rst_tick",   bus.beat_tick, 0);
      chk("rst_done",   bus.track_done, 0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;

      // START track: first tick on the fourth cycle, then 2,3,4,0,1.
      repeat (4) step();
      chk("first_tick_ibeat", bus.ibeat, 1);
      for (int i = 0; i < 5; i++) begin
         repeat (4) step();
         chk("start_seq_ibeat", bus.ibeat, seq_a[i]);
         chk("start_seq_mute", bus.mute, 0);
      end

      // START -> WIN: gap, then one-shot to completion.
      bus.scene = 2'd2;
      step();
      chk("win_gap_track", bus.track, 3);
      chk("win_gap_mute", bus.mute, 1);
      n = 0;
      while (bus.track_done !== 1'b1 && n < 60) begin step(); n++; end
      chk("win_done_seen", (n < 60), 1);
      chk("win_done_ibeat", bus.ibeat, 2);
      chk("win_done_mute", bus.mute, 1);
      repeat (6) step();
      chk("win_hold_ibeat", bus.ibeat, 2);

      // GAME track, SFX at beat 7, resume at 7 then 8.
      bus.scene = 2'd1; bus.boss = 1'b0;
      step();
      n = 0;
      while (!(bus.track === 3'd1 && bus.ibeat === 10'd7) && n < 100) begin step(); n++; end
      chk("game_reach7", (n < 100), 1);
      bus.sfx_req = 1'b1; bus.sfx_id = 2'd2;
      step();
      bus.sfx_req = 1'b0;
      chk("sfx_track", bus.track, 5);
      chk("sfx_sel2", bus.sfx_sel, 2);
      chk("sfx_ibeat0", bus.ibeat, 0);
      n = 0;
      while (bus.track !== 3'd1 && n < 30) begin step(); n++; end
      chk("sfx_return", (n < 30), 1);
      chk("resume_ibeat", bus.ibeat, 7);
      n = 0;
      while (bus.ibeat === 10'd7 && n < 10) begin step(); n++; end
      chk("resume_next", bus.ibeat, 8);

      // Abort SFX with boss change; SFX request during gap is ignored.
      bus.sfx_req = 1'b1; bus.sfx_id = 2'd1;
      step();
      bus.sfx_req = 1'b0;
      n = 0;
      while (!(bus.sfx_active === 1'b1 && bus.ibeat === 10'd1) && n < 10) begin step(); n++; end
      chk("abort_reach1", (n < 10), 1);
      bus.boss = 1'b1;
      step();
      chk("abort_track", bus.track, 2);
      chk("abort_active", bus.sfx_active, 0);
      chk("abort_mute", bus.mute, 1);
      bus.sfx_req = 1'b1;
      step();
      bus.sfx_req = 1'b0;
      chk("gap_req_active", bus.sfx_active, 0);

`ifdef MUSIC_SCHED_PAUSE_EN
      n = 0;
      while (!(bus.track === 3'd2 && bus.ibeat === 10'd3) && n < 60) begin step(); n++; end
      chk("pause_reach3", (n < 60), 1);
      pause_v = 1'b1;
      repeat (10) begin
         step();
         chk("pause_ibeat", bus.ibeat, 3);
         chk("pause_mute", bus.mute, 1);
         chk("pause_tick", bus.beat_tick, 0);
      end
      pause_v = 1'b0;
      n = 0;
      while (bus.ibeat === 10'd3 && n < 10) begin step(); n++; end
      chk("unpause_ibeat", bus.ibeat, 4);
`endif

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 59) == 0) bus.scene = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) bus.boss = ~bus.boss;
         bus.sfx_req = ($urandom_range(0, 11) == 0);
         bus.sfx_id  = 2'($urandom_range(0, 3));
`ifdef MUSIC_SCHED_PAUSE_EN
         if ($urandom_range(0, 29) == 0) pause_v = ~pause_v;
`endif
         step();
      end
      bus.sfx_req = 1'b0;
      pause_v = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
